// File: rtl/pq_wrr_scheduler_if.sv
// Grant handshake between a per-port packet scheduler and the read engine it feeds.
// The master side is the scheduler; the slave side is the read engine and queue status.
interface pq_wrr_scheduler_if #(
    parameter int QUEUES = 8
);
    localparam int PRIO_W = (QUEUES > 1) ? $clog2(QUEUES) : 1;

    logic [QUEUES-1:0] q_nonempty;
    logic              ready;
    logic              pkt_done;
    logic [QUEUES-1:0] grant;
    logic              grant_vld;
    logic              busy;
    logic [PRIO_W-1:0] cur_prio;

    modport master (
        input  q_nonempty, ready, pkt_done,
        output grant, grant_vld, busy, cur_prio
    );

    modport slave (
        output q_nonempty, ready, pkt_done,
        input  grant, grant_vld, busy, cur_prio
    );
endinterface

// File: rtl/pq_wrr_scheduler.sv
// Per-output-port scheduler: picks one of QUEUES priority queues per packet using strict
// priority or weighted round-robin, and holds the grant until the read engine reports EOP.
module pq_wrr_scheduler #(
    parameter int QUEUES   = 8,
    parameter int CREDIT_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wrr_enable,
    input  logic [QUEUES*CREDIT_W-1:0]   weight,
    pq_wrr_scheduler_if.master           sched
);
    localparam int PRIO_W = (QUEUES > 1) ? $clog2(QUEUES) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, WAIT_DONE} state_t;

    state_t              state;
    logic [CREDIT_W-1:0] credit [QUEUES];
    logic [QUEUES-1:0]   eligible;
    logic                any_eligible;
    logic                reload;
    logic [PRIO_W-1:0]   top_nonempty;
    logic [PRIO_W-1:0]   top_eligible;
    logic [PRIO_W-1:0]   sel;

    function automatic logic [CREDIT_W-1:0] weight_of(input int idx);
        logic [CREDIT_W-1:0] w;
        w = weight[idx*CREDIT_W +: CREDIT_W];
        return (w == '0) ? CREDIT_W'(1) : w;
    endfunction

    // NOTE: every variable gets a default before the loop so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        eligible     = '0;
        top_nonempty = '0;
        top_eligible = '0;
        for (int i = 0; i < QUEUES; i++) begin
            eligible[i] = sched.q_nonempty[i] && (credit[i] != '0);
            if (sched.q_nonempty[i]) top_nonempty = PRIO_W'(i);
            if (eligible[i])         top_eligible = PRIO_W'(i);
        end
        any_eligible = |eligible;
        reload       = wrr_enable && !any_eligible;
        sel          = (wrr_enable && any_eligible) ? top_eligible : top_nonempty;
    end

    // NOTE: all state here uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            sched.grant     <= '0;
            sched.grant_vld <= 1'b0;
            sched.busy      <= 1'b0;
            sched.cur_prio  <= '0;
            // NOTE: credits are a small flop array, not RAM, and must reset to 0 so the
            // first WRR decision after reset performs a reload.
            for (int i = 0; i < QUEUES; i++) credit[i] <= '0;
        end else begin
            sched.grant_vld <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sched.ready && |sched.q_nonempty) begin
                        state           <= GRANT;
                        sched.grant     <= QUEUES'(1) << sel;
                        sched.cur_prio  <= sel;
                        sched.busy      <= 1'b1;
                        sched.grant_vld <= 1'b1;
                        if (wrr_enable) begin
                            if (reload) begin
                                for (int i = 0; i < QUEUES; i++)
                                    credit[i] <= (PRIO_W'(i) == sel) ? weight_of(i) - CREDIT_W'(1)
                                                                     : weight_of(i);
                            end else begin
                                credit[sel] <= credit[sel] - CREDIT_W'(1);
                            end
                        end
                    end
                end
                GRANT, WAIT_DONE: begin
                    if (sched.pkt_done) begin
                        state          <= IDLE;
                        sched.grant    <= '0;
                        sched.cur_prio <= '0;
                        sched.busy     <= 1'b0;
                    end else begin
                        state <= WAIT_DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pq_wrr_scheduler.sv
// Scoreboard bench for pq_wrr_scheduler: a queue-level reference model predicts each grant,
// a monitor compares every cycle, and directed plus random phases drive the handshake.
module tb_pq_wrr_scheduler;
    localparam int QUEUES   = 8;
    localparam int CREDIT_W = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       wrr_enable;
    logic [QUEUES*CREDIT_W-1:0] weight;

    pq_wrr_scheduler_if #(.QUEUES(QUEUES)) bus ();

    pq_wrr_scheduler #(.QUEUES(QUEUES), .CREDIT_W(CREDIT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wrr_enable (wrr_enable),
        .weight     (weight),
        .sched      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: credits per queue, one in-flight flag, and expected grants.
    int cr [QUEUES];
    bit m_busy;
    int m_prio;
    int exp_q [$];
    int obs [$];
    int gcount = 0;

    function automatic int highest(input logic [QUEUES-1:0] v);
        for (int i = QUEUES - 1; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int model_pick();
        logic [QUEUES-1:0] elig;
        int p;
        int w;
        if (!wrr_enable) return highest(bus.q_nonempty);
        for (int i = 0; i < QUEUES; i++) elig[i] = bus.q_nonempty[i] && (cr[i] > 0);
        p = highest(elig);
        if (p < 0) begin
            for (int i = 0; i < QUEUES; i++) begin
                w = int'(weight[i*CREDIT_W +: CREDIT_W]);
                cr[i] = (w == 0) ? 1 : w;
            end
            p = highest(bus.q_nonempty);
        end
        cr[p] = cr[p] - 1;
        return p;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_prio = 0;
            for (int i = 0; i < QUEUES; i++) cr[i] = 0;
            exp_q.delete();
        end else if (m_busy) begin
            if (bus.pkt_done) begin
                m_busy = 1'b0;
                m_prio = 0;
            end
        end else if (bus.ready && bus.q_nonempty != '0) begin
            m_prio = model_pick();
            m_busy = 1'b1;
            exp_q.push_back(m_prio);
        end
    end

    // Monitor: outputs are compared on the falling edge, away from the active edge.
    int mon_e;
    always @(negedge clk) begin
        if (rst) begin
            check("rst_grant", bus.grant, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_grant_vld", bus.grant_vld, 0);
        end else begin
            if (bus.grant_vld) begin
                gcount++;
                obs.push_back(int'(bus.cur_prio));
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("grant_prio", bus.cur_prio, mon_e);
                    check("grant_onehot", bus.grant, 1 << mon_e);
                end
            end else if (exp_q.size() != 0) begin
                check("missing_grant", 0, 1);
                exp_q.delete();
            end
            check("busy", bus.busy, m_busy);
            check("held_grant", bus.grant, m_busy ? (1 << m_prio) : 0);
            check("held_prio", bus.cur_prio, m_prio);
        end
    end

    // Read-engine responder: pulses pkt_done a chosen number of cycles after each grant.
    int  done_delay = 2;
    bit  rand_delay = 1'b0;
    int  dcnt = 0;
    int  dly;
    initial begin
        bus.pkt_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.pkt_done = 1'b0;
            if (rst) begin
                dcnt = 0;
            end else if (bus.grant_vld) begin
                dly = rand_delay ? int'($urandom_range(0, 4)) : done_delay;
                if (dly == 0) bus.pkt_done = 1'b1;
                else dcnt = dly;
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) bus.pkt_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int start;
        int c;
        start = gcount;
        c = 0;
        while ((gcount - start) < n && c < budget) begin
            tick();
            c++;
        end
        check("wait_grants", gcount - start, n);
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (bus.busy && c < budget) begin
            tick();
            c++;
        end
        check("wait_idle", bus.busy, 0);
    endtask

    task automatic do_reset();
        bus.ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic check_seq(input string name, input int exp[8], input int n);
        check({name, "_len"}, obs.size(), n);
        for (int i = 0; i < n && i < obs.size(); i++) check(name, obs[i], exp[i]);
    endtask

    int s_strict [8] = '{7, 7, 7, 0, 0, 0, 0, 0};
    int s_ratio  [8] = '{7, 7, 7, 0, 7, 7, 7, 0};
    int s_w0     [8] = '{1, 0, 1, 0, 0, 0, 0, 0};
    int s_mid    [8] = '{2, 2, 2, 0, 0, 0, 0, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        wrr_enable     = 1'b0;
        weight         = '0;
        bus.q_nonempty = 8'hFF;
        bus.ready      = 1'b1;
        done_delay     = 3;

        // Reset held with demand present: no grant until release.
        repeat (5) tick();
        rst = 1'b0;
        tick();
        check("first_grant_vld", bus.grant_vld, 1);
        check("first_grant", bus.grant, 8'h80);
        bus.ready = 1'b0;
        wait_idle(20);

        // Strict priority.
        do_reset();
        wrr_enable = 1'b0;
        bus.q_nonempty = 8'h89;
        done_delay = 3;
        obs.delete();
        bus.ready = 1'b1;
        wait_grants(3, 60);
        bus.ready = 1'b0;
        wait_idle(20);
        check_seq("strict_seq", s_strict, 3);

        // WRR ratio 3:1.
        do_reset();
        wrr_enable = 1'b1;
        weight = '0;
        weight[7*CREDIT_W +: CREDIT_W] = 4'd3;
        weight[0*CREDIT_W +: CREDIT_W] = 4'd1;
        bus.q_nonempty = 8'h81;
        done_delay = 2;
        obs.delete();
        bus.ready = 1'b1;
        wait_grants(8, 120);
        bus.ready = 1'b0;
        wait_idle(20);
        check_seq("wrr_ratio_seq", s_ratio, 8);

        // All weights zero behave as one.
        do_reset();
        weight = '0;
        bus.q_nonempty = 8'h03;
        obs.delete();
        bus.ready = 1'b1;
        wait_grants(4, 80);
        bus.ready = 1'b0;
        wait_idle(20);
        check_seq("weight0_seq", s_w0, 4);

        // Stall on ready, then grant latency, then hold while queues drain.
        do_reset();
        wrr_enable = 1'b0;
        bus.q_nonempty = 8'h10;
        done_delay = 6;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_no_grant", bus.grant_vld, 0);
        end
        bus.ready = 1'b1;
        tick();
        check("stall_release_vld", bus.grant_vld, 1);
        check("stall_release_grant", bus.grant, 8'h10);
        bus.ready = 1'b0;
        tick();
        bus.q_nonempty = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_grant", bus.grant, 8'h10);
            check("hold_busy", bus.busy, 1);
        end
        wait_idle(20);
        check("released_grant", bus.grant, 0);

        // Asynchronous reset in the middle of a packet, then reload from zero credits.
        do_reset();
        wrr_enable = 1'b1;
        weight = '0;
        weight[2*CREDIT_W +: CREDIT_W] = 4'd2;
        bus.q_nonempty = 8'h04;
        done_delay = 8;
        bus.ready = 1'b1;
        wait_grants(1, 20);
        bus.ready = 1'b0;
        tick();
        tick();
        check("mid_busy_before", bus.busy, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_grant", bus.grant, 0);
        check("async_rst_busy", bus.busy, 0);
        tick();
        tick();
        rst = 1'b0;
        done_delay = 2;
        obs.delete();
        bus.ready = 1'b1;
        wait_grants(3, 60);
        bus.ready = 1'b0;
        wait_idle(20);
        check_seq("mid_rst_seq", s_mid, 3);

        // Randomized traffic against the model.
        do_reset();
        rand_delay = 1'b1;
        for (int i = 0; i < 400; i++) begin
            bus.q_nonempty = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            bus.ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) wrr_enable = ~wrr_enable;
            if ($urandom_range(0, 31) == 0) weight = $urandom;
            tick();
        end
        bus.ready = 1'b0;
        wait_idle(50);
        tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
